// File: rtl/next_mon_host.sv
// next_mon_host: host-side initiator for the NeXT monitor/keyboard serial link.
// Generates the free-running mon_clk and shifts 24-bit command frames out on
// to_mon (start 0, data MSB first, stop 1). It can then capture a 24-bit
// response frame from from_mon. Every transaction ends with an idle gap.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   mon_clk             link clock, clk/(2*CLK_DIV)
//   to_mon / from_mon   serial data out (changes on mon_clk fall) / in (sampled on rise)
//   cmd_*               command request handshake (cmd_ready high only in IDLE)
//   resp_*              captured response, framing error and timeout strobes
//   busy                transaction in progress
module next_mon_host #(
    parameter int unsigned CLK_DIV      = 5,
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned GAP_BITS     = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mon_clk,
    output logic        to_mon,
    input  logic        from_mon,
    input  logic [23:0] cmd_data,
    input  logic        cmd_expect_resp,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [23:0] resp_data,
    output logic        resp_valid,
    output logic        resp_frame_err,
    output logic        resp_timeout,
    output logic        busy
);

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned WAIT_W  = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned GAP_W   = $clog2(GAP_BITS + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_START,
        ST_TX_DATA,
        ST_TX_STOP,
        ST_RX_WAIT,
        ST_RX_DATA,
        ST_RX_STOP,
        ST_GAP
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic                 div_wrap;
    logic                 fall_tick;
    logic                 rise_tick;
    logic [1:0]           from_sync;
    logic                 rx_bit;
    logic [FRAME_W-1:0]   tx_shreg;
    logic [FRAME_W-1:0]   rx_shreg;
    logic                 expect_resp;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    // Strobes flag the cycle on which mon_clk is about to toggle
    assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_tick = div_wrap &  mon_clk;
    assign rise_tick = div_wrap & ~mon_clk;

    assign rx_bit    = from_sync[1];
    assign cmd_ready = (state == ST_IDLE) && !reset;
    assign busy      = (state != ST_IDLE);

    // mon_clk divider
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            mon_clk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            mon_clk <= ~mon_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // from_mon synchronizer, reset to the idle-high level
    always_ff @(posedge clk) begin
        if (reset) begin
            from_sync <= 2'b11;
        end else begin
            from_sync <= {from_sync[0], from_mon};
        end
    end

    // Transaction FSM with registered link and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            to_mon         <= 1'b1;
            tx_shreg       <= '0;
            rx_shreg       <= '0;
            expect_resp    <= 1'b0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            resp_data      <= '0;
            resp_valid     <= 1'b0;
            resp_frame_err <= 1'b0;
            resp_timeout   <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_mon <= 1'b1;
                    if (cmd_valid) begin
                        tx_shreg    <= cmd_data;
                        expect_resp <= cmd_expect_resp;
                        state       <= ST_TX_START;
                    end
                end
                ST_TX_START: begin
                    if (fall_tick) begin
                        to_mon  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_TX_DATA;
                    end
                end
                ST_TX_DATA: begin
                    // The fall after the 24th data bit ends bit 0 and starts the stop bit
                    if (fall_tick) begin
                        if (bit_cnt == BIT_W'(FRAME_W)) begin
                            to_mon <= 1'b1;
                            state  <= ST_TX_STOP;
                        end else begin
                            to_mon   <= tx_shreg[FRAME_W-1];
                            tx_shreg <= {tx_shreg[FRAME_W-2:0], 1'b0};
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_TX_STOP: begin
                    // Entry on a fall: that fall already opens the first gap period
                    if (fall_tick) begin
                        if (expect_resp) begin
                            wait_cnt <= '0;
                            state    <= ST_RX_WAIT;
                        end else begin
                            gap_cnt <= GAP_W'(1);
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_RX_WAIT: begin
                    if (rise_tick) begin
                        if (!rx_bit) begin
                            bit_cnt <= '0;
                            state   <= ST_RX_DATA;
                        end else if (wait_cnt == WAIT_W'(RESP_TIMEOUT - 1)) begin
                            resp_timeout <= 1'b1;
                            gap_cnt      <= '0;
                            state        <= ST_GAP;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (rise_tick) begin
                        rx_shreg <= {rx_shreg[FRAME_W-2:0], rx_bit};
                        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            state <= ST_RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_RX_STOP: begin
                    if (rise_tick) begin
                        resp_data      <= rx_shreg;
                        resp_frame_err <= ~rx_bit;
                        resp_valid     <= 1'b1;
                        gap_cnt        <= '0;
                        state          <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Entered from RX on a rise: the first fall only aligns to a period boundary
                    if (fall_tick) begin
                        if (gap_cnt >= GAP_W'(GAP_BITS)) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_next_mon_host.sv
// Directed testbench for next_mon_host: TX framing, response capture,
// response timeout, framing error, held command and mid-frame reset.
module tb_next_mon_host;

    localparam int unsigned CLK_DIV      = 3;
    localparam int unsigned RESP_TIMEOUT = 16;
    localparam int unsigned GAP_BITS     = 4;
    localparam int unsigned PER          = 2 * CLK_DIV;   // clk cycles per mon_clk period

    logic        clk = 1'b0;
    logic        reset;
    logic        mon_clk;
    logic        to_mon;
    logic        from_mon;
    logic [23:0] cmd_data;
    logic        cmd_expect_resp;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] resp_data;
    logic        resp_valid;
    logic        resp_frame_err;
    logic        resp_timeout;
    logic        busy;

    next_mon_host #(
        .CLK_DIV      (CLK_DIV),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .GAP_BITS     (GAP_BITS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mon_clk         (mon_clk),
        .to_mon          (to_mon),
        .from_mon        (from_mon),
        .cmd_data        (cmd_data),
        .cmd_expect_resp (cmd_expect_resp),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .resp_data       (resp_data),
        .resp_valid      (resp_valid),
        .resp_frame_err  (resp_frame_err),
        .resp_timeout    (resp_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    int unsigned t0     = 0;
    int          n_valid = 0;
    int          n_tmo   = 0;
    int unsigned tmo_cyc = 0;
    logic [23:0] last_rd = '0;
    logic        last_fe = 1'b0;

    // Response strobe monitor
    always @(negedge clk) begin
        if (resp_valid) begin
            n_valid = n_valid + 1;
            last_rd = resp_data;
            last_fe = resp_frame_err;
        end
        if (resp_timeout) begin
            n_tmo   = n_tmo + 1;
            tmo_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=hang expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [23:0] data, input logic exp_resp);
        @(negedge clk);
        cmd_data        = data;
        cmd_expect_resp = exp_resp;
        cmd_valid       = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_accept"}, 32'(busy), 32'd1);
    endtask

    // Wait for the start bit on to_mon; t0 marks the first fall of the frame
    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < int'(4 * PER); i++) begin
            @(negedge clk);
            if (to_mon == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        t0 = cyc;
        check({tag, "_start_seen"}, 32'(seen), 32'd1);
    endtask

    // Capture start + 24 data + stop sampled on mon_clk rises
    task automatic tx_frame(input string tag, input logic [23:0] word);
        logic [25:0] got = '0;
        logic [25:0] exp;
        wait_start(tag);
        exp = {1'b0, word, 1'b1};
        for (int i = 0; i < 26; i++) begin
            @(posedge mon_clk);
            #1;
            got = {got[24:0], to_mon};
        end
        check({tag, "_bits"}, 32'(got), 32'(exp));
    endtask

    task automatic wait_ready(input string tag, input int unsigned exp_cycles);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check({tag, "_ready_cycles"}, cyc - t0, exp_cycles);
    endtask

    // Peripheral side: start bit on the fall right after our stop bit
    task automatic respond(input logic [23:0] word, input logic stop);
        @(negedge mon_clk);
        from_mon = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            @(negedge mon_clk);
            from_mon = word[i];
        end
        @(negedge mon_clk);
        from_mon = stop;
        @(negedge mon_clk);
        from_mon = 1'b1;
    endtask

    int v0;
    int m0;

    initial begin
        reset           = 1'b1;
        from_mon        = 1'b1;
        cmd_data        = '0;
        cmd_expect_resp = 1'b0;
        cmd_valid       = 1'b0;
        repeat (4) @(negedge clk);

        check("rst_mon_clk",   32'(mon_clk),        32'd0);
        check("rst_to_mon",    32'(to_mon),         32'd1);
        check("rst_resp_data", 32'(resp_data),      32'd0);
        check("rst_resp_vld",  32'(resp_valid),     32'd0);
        check("rst_frame_err", 32'(resp_frame_err), 32'd0);
        check("rst_timeout",   32'(resp_timeout),   32'd0);
        check("rst_busy",      32'(busy),           32'd0);
        check("rst_cmd_ready", 32'(cmd_ready),      32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Command only: 26 frame periods + GAP_BITS gap periods from the start fall
        v0 = n_valid; m0 = n_tmo;
        send("tx", 24'hC5A301, 1'b0);
        tx_frame("tx", 24'hC5A301);
        wait_ready("tx", (26 + GAP_BITS) * PER);
        check("tx_no_resp_valid", 32'(n_valid - v0), 32'd0);
        check("tx_no_timeout",    32'(n_tmo - m0),    32'd0);

        // Response capture: start at fall 26, stop sampled at rise 51, idle after 5 more falls
        v0 = n_valid;
        send("rx", 24'h3C0F81, 1'b1);
        tx_frame("rx", 24'h3C0F81);
        respond(24'h801234, 1'b1);
        wait_ready("rx", 56 * PER);
        check("rx_valid_pulses", 32'(n_valid - v0), 32'd1);
        check("rx_data",         32'(last_rd),      32'h801234);
        check("rx_frame_err",    32'(last_fe),      32'd0);

        // Timeout: 16th rise in RX_WAIT is rise 41, i.e. 41.5 periods after the start fall
        v0 = n_valid; m0 = n_tmo;
        send("tmo", 24'h0F0F0F, 1'b1);
        tx_frame("tmo", 24'h0F0F0F);
        wait_ready("tmo", 46 * PER);
        check("tmo_pulses",     32'(n_tmo - m0),   32'd1);
        check("tmo_when",       tmo_cyc - t0,      41 * PER + CLK_DIV);
        check("tmo_no_valid",   32'(n_valid - v0), 32'd0);
        check("tmo_data_kept",  32'(resp_data),    32'h801234);

        // Framing error: stop bit driven low
        v0 = n_valid;
        send("ferr", 24'h3C3C3C, 1'b1);
        tx_frame("ferr", 24'h3C3C3C);
        respond(24'h00FFAA, 1'b0);
        wait_ready("ferr", 56 * PER);
        check("ferr_valid_pulses", 32'(n_valid - v0), 32'd1);
        check("ferr_data",         32'(last_rd),      32'h00FFAA);
        check("ferr_flag",         32'(last_fe),      32'd1);

        // cmd_valid held through a frame with new data: taken on the first IDLE cycle
        @(negedge clk);
        cmd_data        = 24'hA5A5A5;
        cmd_expect_resp = 1'b0;
        cmd_valid       = 1'b1;
        @(negedge clk);
        check("held_a_accept", 32'(busy), 32'd1);
        cmd_data = 24'h5A5A5B;
        tx_frame("held_a", 24'hA5A5A5);
        wait_ready("held_a", (26 + GAP_BITS) * PER);
        @(negedge clk);
        check("held_b_accept", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        tx_frame("held_b", 24'h5A5A5B);
        wait_ready("held_b", (26 + GAP_BITS) * PER);

        // Reset during data bit 10, then a clean frame afterwards
        v0 = n_valid; m0 = n_tmo;
        send("rst_tx", 24'h000000, 1'b1);
        wait_start("rst_tx");
        repeat (10) @(negedge mon_clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_to_mon",    32'(to_mon),    32'd1);
        check("abort_mon_clk",   32'(mon_clk),   32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        send("post_rst", 24'h123456, 1'b0);
        tx_frame("post_rst", 24'h123456);
        wait_ready("post_rst", (26 + GAP_BITS) * PER);
        check("abort_no_valid",   32'(n_valid - v0), 32'd0);
        check("abort_no_timeout", 32'(n_tmo - m0),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
